// File: rtl/dmem_responder_pkg.sv
// Shared constants for the MEM-stage data responder: MMIO offsets and
// low-justified lane-enable encodings.
package dmem_responder_pkg;

  localparam logic [7:0] MMIO_LED     = 8'h00;
  localparam logic [7:0] MMIO_SW      = 8'h04;
  localparam logic [7:0] MMIO_CYCLO   = 8'h08;
  localparam logic [7:0] MMIO_CYCHI   = 8'h0C;
  localparam logic [7:0] MMIO_CTRL    = 8'h10;
  localparam logic [7:0] MMIO_ERR     = 8'h14;
  localparam logic [7:0] MMIO_ERRADDR = 8'h18;

  localparam logic [3:0] WE_W = 4'b1111;
  localparam logic [3:0] WE_H = 4'b0011;
  localparam logic [3:0] WE_B = 4'b0001;

  // A store is misaligned when a half crosses a half boundary or a word
  // is not word aligned; bytes can never be misaligned.
  function automatic logic misaligned(input logic [3:0] wea, input logic [1:0] lo);
    return ((wea == WE_H) && lo[0]) || ((wea == WE_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_responder_mmio_regs.sv
// MMIO register file: LED, synchronised switches, 64-bit cycle counter with
// snapshot, sticky misalignment error and its address, plus the read mux.
module dmem_mmio_regs
  import dmem_responder_pkg::*;
#(
  parameter int SW_W  = 16,
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [LED_W-1:0] wd,
  input  logic             wr,
  input  logic             mis,
  input  logic [SW_W-1:0]  sw,
  output logic [31:0]      rd,
  output logic [LED_W-1:0] led,
  output logic             err
);

  logic [1:0][SW_W-1:0] sw_pipe;
  logic [63:0]          cnt;
  logic [63:0]          snap;
  logic [31:0]          err_addr;
  logic [7:0]           off;

  assign off = {addr[7:2], 2'b00};

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (!reset) sw_pipe <= '0;
    else        sw_pipe <= {sw_pipe[0], sw};
  end

  // Free-running counter; a CTRL write captures the pre-increment value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      snap <= '0;
    end else begin
      cnt <= cnt + 64'd1;
      if (wr && off == MMIO_CTRL && wd[0]) snap <= cnt;
    end
  end

  // LED register and sticky error; a new error takes priority over a clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led      <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (wr && off == MMIO_LED) led <= wd;
      if (mis) begin
        err      <= 1'b1;
        err_addr <= addr;
      end else if (wr && off == MMIO_ERR && wd[0]) begin
        err <= 1'b0;
      end
    end
  end

  // Read mux; unmapped and write-only offsets read as zero.
  always_comb begin
    rd = '0;
    case (off)
      MMIO_LED:     rd = 32'(led);
      MMIO_SW:      rd = 32'(sw_pipe[1]);
      MMIO_CYCLO:   rd = snap[31:0];
      MMIO_CYCHI:   rd = snap[63:32];
      MMIO_ERR:     rd = {31'd0, err};
      MMIO_ERRADDR: rd = err_addr;
      default:      rd = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port responder: address decode, byte-lane alignment for
// stores and loads, word-organised RAM and the MMIO register block.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          AW        = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          SW_W      = 16,
  parameter int          LED_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wea_i,
  output logic [31:0]      rdata_o,
  input  logic [SW_W-1:0]  sw_i,
  output logic [LED_W-1:0] led_o,
  output logic             err_o
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] mem [2**AW];

  logic                      mmio;
  logic                      mis;
  logic                      mmio_wr;
  logic [AW-1:0]             idx;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wd;
  logic [31:0]               mmio_rd;
  logic [31:0]               rword;

  assign mmio    = (addr_i[31:8] == MMIO_BASE[31:8]);
  assign idx     = addr_i[AW+1:2];
  assign mis     = misaligned(wea_i, addr_i[1:0]);
  // Only aligned full-word stores reach MMIO; sub-word stores are dropped.
  assign mmio_wr = mmio && (wea_i == WE_W) && !mis;
  assign lane_we = (mmio || mis) ? '0 : (wea_i << addr_i[1:0]);
  assign lane_wd = wdata_i << {addr_i[1:0], 3'b000};

  // Byte-lane RAM write; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (lane_we[l]) mem[idx][l] <= lane_wd[l];
    end
  end

  dmem_mmio_regs #(.SW_W(SW_W), .LED_W(LED_W)) u_regs (
    .clk   (clk),
    .reset (reset),
    .addr  (addr_i),
    .wd    (wdata_i[LED_W-1:0]),
    .wr    (mmio_wr),
    .mis   (mis),
    .sw    (sw_i),
    .rd    (mmio_rd),
    .led   (led_o),
    .err   (err_o)
  );

  // Asynchronous read, right-justified by the byte offset.
  assign rword   = mmio ? mmio_rd : mem[idx];
  assign rdata_o = rword >> {addr_i[1:0], 3'b000};

endmodule
